// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
// Encoding 2'd3 is unused and treated as illegal by the controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full-adder cell.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB first over WIDTH cycles,
// framed by a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CntW-1:0]  cnt;
  logic             cy;
  logic             s_n, c_n;
  logic             load, last;
  logic [WIDTH-1:0] sum_next;

  fa_bit u_fa_bit (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy),
    .s  (s_n),
    .co (c_n)
  );

  assign load     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last     = (state_q == ST_RUN) && (cnt == CntW'(WIDTH - 1));
  assign sum_next = {s_n, sum_sh[WIDTH-1:1]};

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;  // illegal 2'd3 recovers to idle
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      cy      <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        cy     <= ci;
        cnt    <= '0;
        sum_sh <= '0;
      end else if (state_q == ST_RUN) begin
        sum_sh <= sum_next;
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        cy     <= c_n;
        cnt    <= cnt + 1'b1;
        if (last) begin
          s  <= sum_next;
          co <= c_n;
        end
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: drivers push expected results, monitors pop and compare on each done pulse.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, s8;
  logic       start2, ci2, busy2, done2, co2;
  logic [1:0] a2, b2, s2;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .ci(ci2),
    .busy(busy2), .done(done2), .s(s2), .co(co2)
  );

  typedef struct {
    logic [7:0] s;
    logic       co;
    int         dcyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  exp_t e8, e2;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl8", {31'd0, busy8 & done8}, 32'd0);
      if (done8 === 1'b1) begin
        chk("pending_at_done8", {31'd0, q8.size() > 0}, 32'd1);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk("s8", {24'd0, s8}, {24'd0, e8.s});
          chk("co8", {31'd0, co8}, {31'd0, e8.co});
          chk("latency8", cyc, e8.dcyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl2", {31'd0, busy2 & done2}, 32'd0);
      if (done2 === 1'b1) begin
        chk("pending_at_done2", {31'd0, q2.size() > 0}, 32'd1);
        if (q2.size() > 0) begin
          e2 = q2.pop_front();
          chk("s2", {30'd0, s2}, {30'd0, e2.s[1:0]});
          chk("co2", {31'd0, co2}, {31'd0, e2.co});
          chk("latency2", cyc, e2.dcyc);
        end
      end
    end
  end

  task automatic wait_done8();
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      @(negedge clk);
    end
    chk("done_seen8", {31'd0, done8}, 32'd1);
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                      input logic [7:0] es, input logic eco);
    int nb;
    @(negedge clk);
    a8 = ia; b8 = ib; ci8 = ici; start8 = 1'b1;
    q8.push_back('{s: es, co: eco, dcyc: cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) break;
      if (busy8) nb++;
      @(negedge clk);
    end
    chk("done_seen8", {31'd0, done8}, 32'd1);
    chk("busy_cycles8", nb, 8);
  endtask

  task automatic run2(input logic [1:0] ia, input logic [1:0] ib, input logic ici);
    logic [2:0] t;
    t = {1'b0, ia} + {1'b0, ib} + {2'b00, ici};
    @(negedge clk);
    a2 = ia; b2 = ib; ci2 = ici; start2 = 1'b1;
    q2.push_back('{s: {6'd0, t[1:0]}, co: t[2], dcyc: cyc + 3});
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done2) break;
      @(negedge clk);
    end
    chk("done_seen2", {31'd0, done2}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_s", {24'd0, s8}, 32'd0);
    chk("rst_co", {31'd0, co8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

    // Start held high: second operation accepted in the DONE cycle.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
    q8.push_back('{s: 8'h80, co: 1'b0, dcyc: cyc + 9});
    wait_done8();
    a8 = 8'h80; b8 = 8'h80;
    q8.push_back('{s: 8'h00, co: 1'b1, dcyc: cyc + 9});
    wait_done8();
    start8 = 1'b0;
    @(negedge clk);
    chk("idle_busy_after_held", {31'd0, busy8}, 32'd0);
    chk("idle_done_after_held", {31'd0, done8}, 32'd0);

    // Start re-pulsed during RUN is ignored: exactly one done.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
    q8.push_back('{s: 8'h30, co: 1'b0, dcyc: cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
    repeat (12) @(negedge clk);

    // Reset in the fourth RUN cycle aborts and clears results.
    a8 = 8'h11; b8 = 8'h22; ci8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", {31'd0, busy8}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'd0, busy8}, 32'd0);
    chk("midrun_rst_done", {31'd0, done8}, 32'd0);
    chk("midrun_rst_s", {24'd0, s8}, 32'd0);
    chk("midrun_rst_co", {31'd0, co8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

    // WIDTH=2 exhaustive.
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          run2(x[1:0], y[1:0], c[0]);

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
